// File: rtl/seg_pkg.sv
// seg_pkg: state encoding and segment geometry helpers for the segment fill sequencer.
// Rev 1.0
`default_nettype none

package seg_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Widest packed word supported (NSEG = 8).
  localparam int MAX_W = 36;

  function automatic int seg_base(input int k);
    return ((k - 1) * k) / 2;
  endfunction

  // Mask for segment k; zero for k outside 1..nseg.
  function automatic logic [MAX_W-1:0] seg_mask(input int k, input int nseg);
    logic [MAX_W-1:0] m;
    int b;
    m = '0;
    if (k >= 1 && k <= nseg) begin
      b = seg_base(k);
      for (int i = 0; i < MAX_W; i++) begin
        if (i >= b && i < b + k) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_fill_sequencer_unit.sv
// seg_fill_unit: combinational write of one segment (k copies of the fill bit) into the packed word.
// Rev 1.0
`default_nettype none

module seg_fill_unit
  import seg_pkg::*;
#(
  parameter int NSEG = 4,
  parameter int W    = NSEG * (NSEG + 1) / 2,
  parameter int KW   = $clog2(NSEG + 1)
) (
  input  logic [W-1:0]  out_i,
  input  logic [KW-1:0] k_i,
  input  logic          fill_i,
  output logic [W-1:0]  out_o
);

  logic [W-1:0] w_mask;

  always_comb begin
    w_mask = W'(seg_mask(int'(k_i), NSEG));
    out_o  = (out_i & ~w_mask) | (fill_i ? w_mask : '0);
  end

endmodule

`default_nettype wire

// File: rtl/seg_fill_sequencer.sv
// seg_fill_sequencer: fills the packed segment word one segment per clock, then holds it under valid/ready.
// Rev 1.0
`default_nettype none

module seg_fill_sequencer
  import seg_pkg::*;
#(
  parameter int NSEG = 4,
  parameter int W    = NSEG * (NSEG + 1) / 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NSEG-1:0]             sel,
  input  logic                        abort,
  output logic [W-1:0]                out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic [$clog2(NSEG+1)-1:0]   seg_idx
);

  localparam int KW = $clog2(NSEG + 1);

  logic [1:0]      state_q, state_d;
  logic [NSEG-1:0] sel_q, sel_d;
  logic [W-1:0]    out_q, out_d, fill_out;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic [KW-1:0]   idx_q, idx_d;
  logic            fill_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_FILL;
        ST_FILL: if (idx_q == KW'(NSEG)) state_d = ST_HOLD;
        ST_HOLD: if (valid_q && out_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    fill_bit = 1'b0;
    for (int i = 0; i < NSEG; i++) begin
      if (idx_q == KW'(i + 1)) fill_bit = sel_q[i];
    end
  end

  seg_fill_unit #(
    .NSEG (NSEG),
    .W    (W),
    .KW   (KW)
  ) u_fill (
    .out_i  (out_q),
    .k_i    (idx_q),
    .fill_i (fill_bit),
    .out_o  (fill_out)
  );

  always_comb begin
    sel_d   = sel_q;
    out_d   = out_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    if (abort) begin
      out_d   = '0;
      valid_d = 1'b0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sel_d = sel;
            out_d = '0;
            idx_d = KW'(1);
          end
        end
        ST_FILL: begin
          out_d = fill_out;
          if (idx_q == KW'(NSEG)) begin
            valid_d = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + KW'(1);
          end
        end
        ST_HOLD: if (valid_q && out_ready) valid_d = 1'b0;
        default: begin
          out_d   = '0;
          valid_d = 1'b0;
          idx_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign seg_idx   = idx_q;

endmodule

`default_nettype wire
